// File: rtl/axis_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream packet FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_pkg;

  // Release policy of the buffer: word-at-a-time or whole packets only.
  typedef enum logic {
    AXIS_WORD   = 1'b0,
    AXIS_PACKET = 1'b1
  } axis_mode_e;

  // Pointer width for a power-of-two depth; pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Storage array for the stream FIFO: DEPTH x W simple dual-port RAM.
// Latency: write lands on the clock edge, read data is combinational from rd_addr.
// Backpressure: none; the caller only writes free slots.
module axis_fifo_mem #(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_dat
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with tlast framing and optional store-and-forward release.
// Latency: word mode one edge write-to-valid; packet mode valid after the tlast word's edge.
// Backpressure: registered s_tready drops when the FIFO fills; no m_tready->s_tready path.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   oversize
);

  localparam int         PTR_W = ptr_w(DEPTH);
  localparam int         CNT_W = PTR_W + 1;
  localparam axis_mode_e MODE  = (PACKET_MODE != 0) ? AXIS_PACKET : AXIS_WORD;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "axis_packet_fifo: DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "axis_packet_fifo: DATA_WIDTH must be >= 1");
  end

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             s_tready_q, s_tready_d;
  logic             force_q, force_d;
  logic             wr_fire, rd_fire, rd_last, set_force;

  assign wr_entry  = '{last: s_tlast, data: s_tdata};
  assign wr_fire   = s_tvalid & s_tready_q;
  assign rd_fire   = m_tvalid & m_tready;
  assign rd_last   = rd_fire & rd_entry.last;
  // A full buffer holding no packet end can never complete a packet: open the gate once.
  assign set_force = (MODE == AXIS_PACKET) && (fill_q == CNT_W'(DEPTH)) &&
                     (pkt_q == '0) && !force_q;

  axis_fifo_mem #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_dat  (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_entry)
  );

  // Output valid: any stored word in word mode; a complete packet (or forced drain) in packet mode.
  always_comb begin
    m_tvalid = 1'b0;
    if (MODE == AXIS_PACKET) begin
      m_tvalid = (pkt_q != '0) | (force_q & (fill_q != '0));
    end else begin
      m_tvalid = (fill_q != '0);
    end
  end

  // Next-state for pointers, occupancy/packet counters, forced-drain flag and ready.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    pkt_d    = pkt_q;
    force_d  = force_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_fire, rd_fire})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
    case ({wr_fire & s_tlast, rd_last})
      2'b10:   pkt_d = pkt_q + CNT_W'(1);
      2'b01:   pkt_d = pkt_q - CNT_W'(1);
      default: pkt_d = pkt_q;
    endcase
    if (set_force) begin
      force_d = 1'b1;
    end else if (rd_last) begin
      force_d = 1'b0;
    end
    s_tready_d = (fill_d != CNT_W'(DEPTH));
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      pkt_q      <= '0;
      force_q    <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      pkt_q      <= pkt_d;
      force_q    <= force_d;
      s_tready_q <= s_tready_d;
    end
  end

  assign s_tready   = s_tready_q;
  assign m_tdata    = rd_entry.data;
  assign m_tlast    = rd_entry.last;
  assign fill_count = fill_q;
  assign pkt_count  = pkt_q;
  assign oversize   = set_force;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: word-mode and packet-mode instances side by side.
// Each step drives one instance for one cycle; the other instance is held idle.
// Expected outputs come from a queue-based model of the stream contents.
module tb_axis_packet_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata    [2];
  logic          s_tvalid   [2];
  logic          s_tlast    [2];
  logic          s_tready   [2];
  logic [DW-1:0] m_tdata    [2];
  logic          m_tvalid   [2];
  logic          m_tlast    [2];
  logic          m_tready   [2];
  logic [CW-1:0] fill_count [2];
  logic [CW-1:0] pkt_count  [2];
  logic          oversize   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_packet_fifo #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .PACKET_MODE (g)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_tdata    (s_tdata[g]),
      .s_tvalid   (s_tvalid[g]),
      .s_tlast    (s_tlast[g]),
      .s_tready   (s_tready[g]),
      .m_tdata    (m_tdata[g]),
      .m_tvalid   (m_tvalid[g]),
      .m_tlast    (m_tlast[g]),
      .m_tready   (m_tready[g]),
      .fill_count (fill_count[g]),
      .pkt_count  (pkt_count[g]),
      .oversize   (oversize[g])
    );
  end

  // Reference model: stored {last,data} words in arrival order, plus the forced-drain flag.
  logic [DW:0] mq [2][$];
  bit          exp_rdy [2];
  bit          frc     [2];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int lasts(input int k);
    int n = 0;
    foreach (mq[k][i]) if (mq[k][i][DW]) n++;
    return n;
  endfunction

  // One cycle on instance k: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input int k, input bit vld, input bit last, input logic [DW-1:0] d, input bit rdy);
    bit          ev, eo, wr, rd;
    int          nl;
    logic [DW:0] head;
    s_tvalid[k] = vld;
    s_tlast[k]  = last;
    s_tdata[k]  = d;
    m_tready[k] = rdy;
    @(negedge clk);
    nl = lasts(k);
    if (k == 1) ev = (nl != 0) || (frc[k] && mq[k].size() != 0);
    else        ev = (mq[k].size() != 0);
    eo = (k == 1) && (mq[k].size() == DEPTH) && (nl == 0) && !frc[k];
    chk("s_tready",   k, s_tready[k],   exp_rdy[k]);
    chk("fill_count", k, fill_count[k], mq[k].size());
    chk("pkt_count",  k, pkt_count[k],  nl);
    chk("m_tvalid",   k, m_tvalid[k],   ev);
    chk("oversize",   k, oversize[k],   eo);
    if (ev) begin
      head = mq[k][0];
      chk("m_tdata", k, m_tdata[k], head[DW-1:0]);
      chk("m_tlast", k, m_tlast[k], head[DW]);
    end
    wr = vld && exp_rdy[k];
    rd = ev && rdy;
    @(posedge clk);
    if (rd) begin
      head = mq[k].pop_front();
      if (frc[k] && head[DW]) frc[k] = 1'b0;
    end
    if (wr) mq[k].push_back({last, d});
    if (eo) frc[k] = 1'b1;
    exp_rdy[k] = (mq[k].size() != DEPTH);
    #1;
    s_tvalid[k] = 1'b0;
    m_tready[k] = 1'b0;
  endtask

  // Asynchronous reset away from any clock edge, released mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_s_tready", k, s_tready[k],   0);
      chk("rst_m_tvalid", k, m_tvalid[k],   0);
      chk("rst_fill",     k, fill_count[k], 0);
      chk("rst_pkt",      k, pkt_count[k],  0);
      chk("rst_oversize", k, oversize[k],   0);
      mq[k].delete();
      frc[k]     = 1'b0;
      exp_rdy[k] = 1'b0;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) chk("rdy_before_edge", k, s_tready[k], 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k] = 1'b1;
      chk("rdy_after_edge", k, s_tready[k], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_tdata[k] = '0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; m_tready[k] = 1'b0;
      exp_rdy[k] = 1'b0; frc[k] = 1'b0;
    end
    #1;
    do_reset();

    // 1: reset in the middle of a burst
    for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(16'h0100 + i), 0);
    do_reset();

    // 2: word mode fill to full, ninth word held off, drain in order
    for (int i = 1; i <= 8; i++) step(0, 1, 0, DW'(i), 0);
    chk("full_fill",  0, fill_count[0], 8);
    chk("full_ready", 0, s_tready[0],   0);
    step(0, 1, 0, 16'h0009, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 16'h0000, 1);
    chk("drained", 0, fill_count[0], 0);

    // 3: four stored, then write and read every cycle across the pointer wrap
    for (int i = 0; i < 4; i++) step(0, 1, 0, DW'(16'h0200 + i), 0);
    for (int i = 0; i < 20; i++) step(0, 1, i[0], DW'(16'h0300 + i), 1);
    chk("steady_fill", 0, fill_count[0], 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000, 1);

    // 4: packet mode holds a packet until its tlast word is stored
    step(1, 1, 0, 16'h000A, 1);
    step(1, 1, 0, 16'h000B, 1);
    step(1, 1, 1, 16'h000C, 1);
    chk("pkt_one", 1, pkt_count[1], 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0000, 1);
    chk("pkt_zero", 1, pkt_count[1], 0);

    // 5: packet mode oversize, forced drain, then normal store-and-forward again
    for (int i = 0; i < 8; i++) step(1, 1, 0, DW'(16'h0050 + i), 0);
    step(1, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0000, 1);
    step(1, 1, 1, 16'h005F, 1);
    step(1, 0, 0, 16'h0000, 1);
    step(1, 1, 0, 16'h0060, 1);
    step(1, 1, 1, 16'h0061, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0000, 1);
    chk("after_oversize", 1, fill_count[1], 0);

    // 6: random traffic with 30% downstream ready on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 250; i++)
        step(k, ($urandom % 2) == 0, ($urandom % 4) == 0, DW'($urandom), ($urandom % 10) < 3);
      for (int i = 0; i < 20; i++) step(k, 0, 0, 16'h0000, 1);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
